flit_rx_assembler: RTL and testbench

//  Receive end of the UART flit link. Takes the byte stream from the UART receiver and

---
 rtl/flit_rx_assembler.sv | 195 +++++++++++++++++++
 tb/tb_flit_rx_assembler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_rx_assembler.sv
// Receive side of the UART flit link: rebuilds 128-bit flits (MSB byte first) from the byte stream,
// verifies the word checksum, filters on destination id and hands flits over a one-entry buffer.
module flit_rx_assembler #(
    parameter int TIMEOUT_CYCLES = 17360
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   my_id,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic [127:0] flit_out,
    output logic         flit_valid,
    input  logic         flit_ready,
    output logic         ack_req_valid,
    output logic [7:0]   ack_req_dst,
    output logic [15:0]  ack_req_flit_id,
    output logic         err_checksum,
    output logic         err_timeout,
    output logic         err_overflow
);

    localparam int           TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]   BROADCAST_ID = 8'hFF;
    localparam logic [3:0]   FT_SYSTEM    = 4'h3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // Flit header layout: [127:124] flittype, [123] is_ack, [119:112] src_id,
    // [111:104] dst_id, [103:88] flit_id, [15:0] checksum.
    function automatic logic [15:0] flit_checksum(input logic [127:0] f);
        logic [15:0] sum;
        sum = 16'h0000;
        for (int i = 0; i < 7; i++) begin
            sum = sum + f[127-16*i -: 16];
        end
        return sum;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      cnt_r;
    logic [TW-1:0]   timer_r;
    logic [127:0]    shreg_r;
    logic            store_s;
    logic            first_s;
    logic            timeout_s;
    logic            check_s;

    logic [3:0]      ftype_s;
    logic            is_ack_s;
    logic [7:0]      src_s;
    logic [7:0]      dst_s;
    logic [15:0]     fid_s;
    logic            sum_ok_s;
    logic            dst_ok_s;
    logic            accept_s;
    logic            load_s;
    logic            overflow_s;
    logic            ack_s;
    logic            cks_err_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and byte-acceptance decode.
    always_comb begin
        state_s   = state_r;
        store_s   = 1'b0;
        first_s   = 1'b0;
        timeout_s = 1'b0;
        check_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (rx_valid) begin
                    store_s = 1'b1;
                    first_s = 1'b1;
                    state_s = S_RECV;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    store_s = 1'b1;
                    if (cnt_r == 4'd15) begin
                        state_s = S_CHECK;
                    end else begin
                        state_s = S_RECV;
                    end
                end else if (timer_r == TO_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = S_IDLE;
                end else begin
                    state_s = S_RECV;
                end
            end
            S_CHECK: begin
                check_s = 1'b1;
                if (rx_valid) begin
                    store_s = 1'b1;
                    first_s = 1'b1;
                    state_s = S_RECV;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Byte shift register, byte counter and inter-byte timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= 128'h0;
            cnt_r   <= 4'd0;
            timer_r <= '0;
        end else begin
            if (store_s) begin
                shreg_r <= {shreg_r[119:0], rx_data};
                cnt_r   <= first_s ? 4'd1 : (cnt_r + 4'd1);
                timer_r <= '0;
            end else if (timeout_s) begin
                cnt_r   <= 4'd0;
                timer_r <= '0;
            end else if (state_r == S_RECV) begin
                timer_r <= timer_r + TW'(1);
            end else begin
                timer_r <= '0;
            end
        end
    end

    assign ftype_s    = shreg_r[127:124];
    assign is_ack_s   = shreg_r[123];
    assign src_s      = shreg_r[119:112];
    assign dst_s      = shreg_r[111:104];
    assign fid_s      = shreg_r[103:88];
    assign sum_ok_s   = (flit_checksum(shreg_r) == shreg_r[15:0]);
    assign dst_ok_s   = (dst_s == my_id) || (dst_s == BROADCAST_ID);
    assign accept_s   = check_s && sum_ok_s && dst_ok_s;
    assign load_s     = accept_s && (!flit_valid || flit_ready);
    assign overflow_s = accept_s && flit_valid && !flit_ready;
    assign cks_err_s  = check_s && !sum_ok_s;
    // An overflowed flit was still received intact, so it is acknowledged too.
    assign ack_s      = accept_s && !is_ack_s && (dst_s == my_id) &&
                        (dst_s != BROADCAST_ID) && (ftype_s != FT_SYSTEM);

    // Output buffer, ACK request and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_out        <= 128'h0;
            flit_valid      <= 1'b0;
            ack_req_valid   <= 1'b0;
            ack_req_dst     <= 8'h00;
            ack_req_flit_id <= 16'h0000;
            err_checksum    <= 1'b0;
            err_timeout     <= 1'b0;
            err_overflow    <= 1'b0;
        end else begin
            if (load_s) begin
                flit_out   <= shreg_r;
                flit_valid <= 1'b1;
            end else if (flit_ready) begin
                flit_valid <= 1'b0;
            end else begin
                flit_valid <= flit_valid;
            end
            ack_req_valid <= ack_s;
            if (ack_s) begin
                ack_req_dst     <= src_s;
                ack_req_flit_id <= fid_s;
            end else begin
                ack_req_dst     <= ack_req_dst;
                ack_req_flit_id <= ack_req_flit_id;
            end
            err_checksum <= cks_err_s;
            err_timeout  <= timeout_s;
            err_overflow <= overflow_s;
        end
    end

endmodule

// File: tb/tb_flit_rx_assembler.sv
// Scoreboard bench for flit_rx_assembler: directed scenarios plus random flits, checked against a
// flit-level reference model (checksum, filter, one-entry buffer, ACK rules).
module tb_flit_rx_assembler;

    localparam int TO = 17360;

    typedef struct {
        logic [23:0] v;
        longint      t;
    } ack_ev_t;

    typedef struct {
        int     code;
        longint t;
    } err_ev_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   my_id = 8'h05;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic [127:0] flit_out;
    logic         flit_valid;
    logic         flit_ready = 1'b0;
    logic         ack_req_valid;
    logic [7:0]   ack_req_dst;
    logic [15:0]  ack_req_flit_id;
    logic         err_checksum;
    logic         err_timeout;
    logic         err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_flit_q[$];
    ack_ev_t      ack_q[$];
    err_ev_t      err_q[$];

    bit           model_full = 1'b0;
    bit           chk_pending = 1'b0;
    bit           rand_ready_en = 1'b0;
    logic [127:0] chk_flit;

    always #5 clk = ~clk;

    flit_rx_assembler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .my_id(my_id), .rx_valid(rx_valid), .rx_data(rx_data),
        .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .ack_req_valid(ack_req_valid), .ack_req_dst(ack_req_dst), .ack_req_flit_id(ack_req_flit_id),
        .err_checksum(err_checksum), .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_sum(input logic [111:0] body);
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < 7; i++) s = s + body[111-16*i -: 16];
        return s;
    endfunction

    function automatic logic [127:0] mk(input logic [7:0] b0, input logic [7:0] src,
                                        input logic [7:0] dst, input logic [15:0] fid,
                                        input logic [71:0] pl);
        logic [111:0] body;
        body = {b0, src, dst, fid, pl};
        return {body, word_sum(body)};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_flit(input logic [127:0] f, input int gmax);
        for (int k = 0; k < 16; k++) begin
            send_byte(f[127-8*k -: 8]);
            if (k < 15) idle($urandom_range(0, gmax));
        end
        chk_flit    = f;
        chk_pending = 1'b1;
    endtask

    task automatic wait_timeout(input string name);
        int seen;
        seen = 0;
        err_q.push_back('{2, -1});
        for (int i = 1; i <= TO + 10 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (err_timeout) seen = i;
        end
        check(name, 128'(seen), 128'(TO));
    endtask

    // Reference model: evaluates each complete flit on the edge after its last byte.
    initial begin : model
        logic         loaded;
        logic [127:0] f;
        forever begin
            @(posedge clk);
            loaded = 1'b0;
            if (!rst_n) begin
                model_full  = 1'b0;
                chk_pending = 1'b0;
            end else begin
                if (chk_pending) begin
                    chk_pending = 1'b0;
                    f = chk_flit;
                    if (word_sum(f[127:16]) != f[15:0]) begin
                        err_q.push_back('{1, longint'($time)});
                    end else if (f[111:104] == my_id || f[111:104] == 8'hFF) begin
                        if (!model_full || flit_ready) begin
                            exp_flit_q.push_back(f);
                            model_full = 1'b1;
                            loaded = 1'b1;
                        end else begin
                            err_q.push_back('{3, longint'($time)});
                        end
                        if (!f[123] && f[111:104] == my_id && my_id != 8'hFF && f[127:124] != 4'h3)
                            ack_q.push_back('{{f[119:112], f[103:88]}, longint'($time)});
                    end
                end
                if (!loaded && flit_ready) model_full = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a handshake or pulse.
    initial begin : monitor
        logic [127:0] ef;
        ack_ev_t      ae;
        err_ev_t      ee;
        int           code;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (flit_valid && flit_ready) begin
                    if (exp_flit_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL flit_unexpected: got %h expected none", flit_out);
                    end else begin
                        ef = exp_flit_q.pop_front();
                        check("flit_data", flit_out, ef);
                    end
                end
                if (ack_req_valid) begin
                    if (ack_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL ack_unexpected: got %h_%h expected none", ack_req_dst, ack_req_flit_id);
                    end else begin
                        ae = ack_q.pop_front();
                        check("ack_fields", {ack_req_dst, ack_req_flit_id}, ae.v);
                        check("ack_time", 128'(longint'($time) - ae.t), 128'd5);
                    end
                end
                if (err_checksum || err_timeout || err_overflow) begin
                    code = err_checksum ? 1 : (err_timeout ? 2 : 3);
                    if (int'(err_checksum) + int'(err_timeout) + int'(err_overflow) > 1) code = 9;
                    if (err_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL err_unexpected: got code %0d expected none", code);
                    end else begin
                        ee = err_q.pop_front();
                        check("err_code", 128'(code), 128'(ee.code));
                        if (ee.t >= 0) check("err_time", 128'(longint'($time) - ee.t), 128'd5);
                    end
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) flit_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : stim
        logic [127:0] f1, fa, fb, f;
        logic [7:0]   b0, dst;
        #1;
        check("reset_ctrl", {flit_valid, ack_req_valid, err_checksum, err_timeout, err_overflow,
                             ack_req_dst, ack_req_flit_id}, 128'h0);
        check("reset_flit_out", flit_out, 128'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // T1: basic unicast data flit, held with flit_ready low.
        f1 = mk(8'h00, 8'h03, 8'h05, 16'h0100, 72'h0);
        send_flit(f1, 0);
        check("t1_valid_early", 128'(flit_valid), 128'd0);
        idle(1);
        check("t1_valid_lat", 128'(flit_valid), 128'd1);
        check("t1_hdr", 128'(flit_out[127:88]), 128'h0003050100);
        check("t1_cks", 128'(flit_out[15:0]), 128'h0504);
        flit_ready = 1'b1;
        idle(2);

        // T2: corrupted checksum.
        send_flit({f1[127:8], 8'h05}, 1);
        idle(3);
        check("t2_no_valid", 128'(flit_valid), 128'd0);

        // T3: broadcast, foreign dst, is_ack and SYSTEM flits.
        send_flit(mk(8'h00, 8'h03, 8'hFF, 16'h0100, 72'h0), 1);
        send_flit(mk(8'h00, 8'h03, 8'h07, 16'h0100, 72'h0), 1);
        send_flit(mk(8'h08, 8'h03, 8'h05, 16'h0101, 72'h0), 1);
        send_flit(mk(8'h30, 8'h03, 8'h05, 16'h0102, 72'h0), 1);
        idle(3);

        // T4: overflow with a full buffer, then replacement in the check cycle.
        fa = f1;
        fb = mk(8'h00, 8'h03, 8'h05, 16'h0200, 72'h0);
        flit_ready = 1'b0;
        send_flit(fa, 0);
        send_flit(fb, 0);
        idle(1);
        check("t4_hold_valid", 128'(flit_valid), 128'd1);
        check("t4_hold_data", flit_out, fa);
        flit_ready = 1'b1;
        idle(1);
        flit_ready = 1'b0;
        send_flit(fa, 0);
        send_flit(fb, 0);
        flit_ready = 1'b1;
        idle(1);
        flit_ready = 1'b0;
        check("t4_no_bubble", 128'(flit_valid), 128'd1);
        check("t4_replaced", flit_out, fb);
        flit_ready = 1'b1;
        idle(2);

        // T5: inter-byte timeout, then a normal flit.
        for (int k = 0; k < 7; k++) send_byte(f1[127-8*k -: 8]);
        wait_timeout("t5_timeout_lat");
        send_flit(f1, 2);
        idle(3);

        // T6: reset mid-flit.
        for (int k = 0; k < 10; k++) send_byte(f1[127-8*k -: 8]);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {flit_valid, ack_req_valid, err_checksum, err_timeout, err_overflow,
                              ack_req_dst, ack_req_flit_id}, 128'h0);
        check("t6_rst_flit_out", flit_out, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 10; k < 16; k++) send_byte(f1[127-8*k -: 8]);
        wait_timeout("t6_timeout_lat");
        send_flit(mk(8'h00, 8'h09, 8'h05, 16'h0300, 72'h0), 1);
        idle(3);

        // Random flits with random back-pressure.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0:       b0 = 8'h00;
                1:       b0 = 8'h08;
                2:       b0 = 8'h30;
                default: b0 = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1:    dst = my_id;
                2:       dst = 8'hFF;
                default: dst = 8'($urandom);
            endcase
            f = mk(b0, 8'($urandom), dst, 16'($urandom), {$urandom, $urandom, 8'($urandom)});
            if ($urandom_range(0, 4) == 0) f[15:0] = f[15:0] ^ (16'h0001 << $urandom_range(0, 15));
            send_flit(f, 2);
            idle($urandom_range(0, 3));
        end
        rand_ready_en = 1'b0;
        flit_ready = 1'b1;
        idle(6);

        check("end_flit_q", 128'(exp_flit_q.size()), 128'd0);
        check("end_ack_q", 128'(ack_q.size()), 128'd0);
        check("end_err_q", 128'(err_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
